// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
//   - Register map addresses for the cfg bus
//   - FSM state encoding
//   - Reset value of TIMER_CMP
package irq_pkg;

    localparam logic [1:0] AddrEnable   = 2'd0;
    localparam logic [1:0] AddrMode     = 2'd1;
    localparam logic [1:0] AddrPending  = 2'd2;
    localparam logic [1:0] AddrTimerCmp = 2'd3;

    localparam logic [31:0] TimerCmpRst = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// Bus between the interrupt controller and its environment (interrupt lines,
// config register port and core handshake).
//   master : drives irq_in, cfg_we/addr/wdata, irq_ack, irq_done
//   slave  : the controller; drives cfg_rdata, irq_req, irq_id
interface irq_ctrl_if #(
    parameter int unsigned N_IRQ = 8,
    parameter int unsigned ID_W  = $clog2(N_IRQ)
);
    logic [N_IRQ-1:0] irq_in;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [31:0]      cfg_wdata;
    logic [31:0]      cfg_rdata;
    logic             irq_req;
    logic [ID_W-1:0]  irq_id;
    logic             irq_ack;
    logic             irq_done;

    modport master (
        output irq_in, cfg_we, cfg_addr, cfg_wdata, irq_ack, irq_done,
        input  cfg_rdata, irq_req, irq_id
    );

    modport slave (
        input  irq_in, cfg_we, cfg_addr, cfg_wdata, irq_ack, irq_done,
        output cfg_rdata, irq_req, irq_id
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req_i.
//   req_i   : request vector
//   id_o    : index of the lowest set bit (0 when none set)
//   valid_o : any bit of req_i set
module irq_prio_enc #(
    parameter int unsigned N_IRQ = 8,
    parameter int unsigned ID_W  = $clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] req_i,
    output logic [ID_W-1:0]  id_o,
    output logic             valid_o
);

    always_comb begin
        id_o    = '0;
        valid_o = |req_i;
        // Scan downwards so the lowest index is the last to assign.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller with per-channel edge/level capture, enable mask,
// fixed lowest-index priority and a REQ/ACK/DONE handshake to the core.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : irq_ctrl_if slave (irq lines, cfg register port, core handshake)
// Registers: 0 ENABLE, 1 MODE (1=edge), 2 PENDING (W1C), 3 TIMER_CMP.
// Optional feature macro IRQ_TIMER_EN: free-running 32-bit counter whose
// match with TIMER_CMP raises an edge event on channel 0. Without it the
// counter is absent and TIMER_CMP reads 0.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned N_IRQ = 8,
    parameter int unsigned ID_W  = $clog2(N_IRQ)
) (
    input logic       clk,
    input logic       reset,
    irq_ctrl_if.slave bus
);

    irq_state_e       state_q, state_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic [N_IRQ-1:0] enable_q, enable_d;
    logic [N_IRQ-1:0] mode_q, mode_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] irq_prev_q;

    logic [N_IRQ-1:0] set_vec;
    logic [N_IRQ-1:0] clr_vec;
    logic [ID_W-1:0]  prio_id;
    logic             prio_valid;
    logic             timer_hit;
    logic [31:0]      rdata;
    logic             wr_enable, wr_mode, wr_pending;
    logic             unused_wdata;

    assign wr_enable  = bus.cfg_we && (bus.cfg_addr == AddrEnable);
    assign wr_mode    = bus.cfg_we && (bus.cfg_addr == AddrMode);
    assign wr_pending = bus.cfg_we && (bus.cfg_addr == AddrPending);

    // Upper write-data bits are meaningless for narrow registers.
    assign unused_wdata = ^bus.cfg_wdata;

`ifdef IRQ_TIMER_EN
    logic [31:0] timer_cnt_q;
    logic [31:0] timer_cmp_q, timer_cmp_d;
    logic        wr_timer;

    assign wr_timer  = bus.cfg_we && (bus.cfg_addr == AddrTimerCmp);
    assign timer_hit = (timer_cnt_q == timer_cmp_q);

    always_comb begin
        timer_cmp_d = timer_cmp_q;
        if (wr_timer) begin
            timer_cmp_d = bus.cfg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_cnt_q <= '0;
            timer_cmp_q <= TimerCmpRst;
        end else begin
            timer_cnt_q <= timer_cnt_q + 32'd1;
            timer_cmp_q <= timer_cmp_d;
        end
    end
`else
    assign timer_hit = 1'b0;
`endif

    // Capture: level channels pend while high, edge channels on a 0->1 step.
    always_comb begin
        set_vec    = (bus.irq_in & ~mode_q) | (bus.irq_in & mode_q & ~irq_prev_q);
        set_vec[0] = set_vec[0] | timer_hit;
    end

    always_comb begin
        clr_vec = '0;
        if (wr_pending) begin
            clr_vec = bus.cfg_wdata[N_IRQ-1:0];
        end
        if ((state_q == StReq) && bus.irq_ack) begin
            clr_vec[irq_id_q] = 1'b1;
        end
    end

    // Set dominates clear so a fresh event is never lost.
    always_comb begin
        pending_d = (pending_q & ~clr_vec) | set_vec;
        enable_d  = wr_enable ? bus.cfg_wdata[N_IRQ-1:0] : enable_q;
        mode_d    = wr_mode ? bus.cfg_wdata[N_IRQ-1:0] : mode_q;
    end

    irq_prio_enc #(
        .N_IRQ (N_IRQ),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req_i   (pending_q & enable_q),
        .id_o    (prio_id),
        .valid_o (prio_valid)
    );

    // Winner is latched on leaving IDLE and held until ack regardless of
    // later enable/pending changes.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        unique case (state_q)
            StIdle: begin
                if (prio_valid) begin
                    state_d  = StReq;
                    irq_id_d = prio_id;
                end
            end
            StReq: begin
                if (bus.irq_ack) begin
                    state_d = StService;
                end
            end
            StService: begin
                if (bus.irq_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            irq_id_q   <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            pending_q  <= '0;
            irq_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            irq_id_q   <= irq_id_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            pending_q  <= pending_d;
            irq_prev_q <= bus.irq_in;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (bus.cfg_addr)
            AddrEnable:  rdata = 32'(enable_q);
            AddrMode:    rdata = 32'(mode_q);
            AddrPending: rdata = 32'(pending_q);
`ifdef IRQ_TIMER_EN
            AddrTimerCmp: rdata = timer_cmp_q;
`else
            AddrTimerCmp: rdata = '0;
`endif
            default: rdata = '0;
        endcase
    end

    assign bus.cfg_rdata = rdata;
    assign bus.irq_req   = (state_q == StReq);
    assign bus.irq_id    = irq_id_q;

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 8, number of external interrupt channels (2..32).
REQ-002 Parameter ID_W, default $clog2(N_IRQ), width of the interrupt id.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 irq_in  input  N_IRQ  external interrupt lines, already synchronous to clk.
REQ-006 cfg_we  input  1  config register write strobe.
REQ-007 cfg_addr  input  2  register select: 0 ENABLE, 1 MODE (1=edge, 0=level), 2 PENDING, 3 TIMER_CMP.
REQ-008 cfg_wdata  input  32  write data.
REQ-009 cfg_rdata  output  32  combinational read of the register at cfg_addr; unused upper bits read 0.
REQ-010 irq_req  output  1  interrupt request to the core.
REQ-011 irq_id  output  ID_W  id of the requested channel; valid while irq_req=1.
REQ-012 irq_ack  input  1  core accepts the request (1-cycle pulse).
REQ-013 irq_done  input  1  core end-of-interrupt (1-cycle pulse).

Function
REQ-014 Channel i edge mode shall set pending[i] on the cycle irq_in[i]=1 and its previous registered sample=0.
REQ-015 Level mode shall set pending[i] every cycle irq_in[i]=1.
REQ-016 Priority is fixed: lowest index among (pending & enable) wins.
REQ-017 FSM states IDLE, REQ, SERVICE; IDLE->REQ when (pending & enable)!=0, latching winner into irq_id and asserting irq_req on the next cycle.
REQ-018 In REQ, irq_req and irq_id shall stay stable until irq_ack, even if enable or pending change.
REQ-019 REQ->SERVICE on irq_ack: irq_req deasserts next cycle and pending[irq_id] clears.
REQ-020 SERVICE->IDLE on irq_done; irq_ack/irq_done in any other state are ignored.
REQ-021 Latency: irq_in edge at cycle k -> pending at k+1 -> irq_req=1 at k+2 when IDLE.
REQ-022 Writing PENDING is write-1-to-clear; ENABLE, MODE, TIMER_CMP are plain writes.
REQ-023 Simultaneous set and clear (ack or W1C) of the same pending bit: set wins.
REQ-024 Level channel still high after ack shall re-pend the following cycle.
REQ-025 Pending bits of disabled channels are retained and requestable once enabled.

Reset
REQ-026 On reset: FSM=IDLE, irq_req=0, irq_id=0, pending=0, ENABLE=0, MODE=0, input sample register=0, timer counter=0, TIMER_CMP=0xFFFFFFFF.
REQ-027 Reset during REQ or SERVICE shall abort the handshake; irq_req=0 the cycle after reset is sampled.

Configuration
REQ-028 Macro IRQ_TIMER_EN.
REQ-029 Defined: 32-bit free-running counter increments each cycle, wraps at 0xFFFFFFFF->0; counter==TIMER_CMP sets pending[0] as an edge event, ORed with irq_in[0].
REQ-030 Undefined: no counter, TIMER_CMP reads 0, writes to it ignored, channel 0 behaves as any channel.

Structure
REQ-031 Package irq_pkg holds register address constants, the FSM state enum, and the TIMER_CMP reset value.
REQ-032 Sub-module irq_prio_enc: combinational N_IRQ-to-ID_W lowest-index priority encoder with valid output.

Verification
REQ-033 Edge ch3, ENABLE=0x08, MODE=0x08, irq_in[3] 0->1 at cycle 10 -> irq_req=1, irq_id=3 at cycle 12; ack -> PENDING reads 0.
REQ-034 Ch2 and ch5 pend in the same cycle, both enabled -> irq_id=2 first; after ack+done -> irq_id=5.
REQ-035 Level ch1 held high through ack -> PENDING[1]=1 again one cycle after ack; new request after irq_done.
REQ-036 New edge on ch4 in the same cycle as W1C of PENDING[4] -> PENDING[4] reads 1.
REQ-037 Reset asserted in SERVICE -> next cycle irq_req=0, PENDING=0, ENABLE=0; a later irq_done is ignored.
REQ-038 IRQ_TIMER_EN: TIMER_CMP=20, ENABLE=0x01, MODE=0x01 -> irq_req=1, irq_id=0 two cycles after counter reaches 20; without macro TIMER_CMP reads 0.
